// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, reads words from instruction memory over req/ack
// and hands them to the decoder over valid/ready. Optional macro: FETCH_MISALIGN_TRAP_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nreset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instPc_q, instPc_d;
    logic        instValid_q, instValid_d;
    logic        fault_q, fault_d;
    logic        kill_q, kill_d;
    logic [31:0] killPc_q, killPc_d;

    logic [31:0] redirTarget;
    logic        misalign;

    assign redirTarget = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
    logic unusedLowBits;
    assign unusedLowBits = ^redirect_pc[1:0];
    assign misalign      = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            instPc_q    <= RESET_PC;
            instValid_q <= 1'b0;
            fault_q     <= 1'b0;
            kill_q      <= 1'b0;
            killPc_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            instPc_q    <= instPc_d;
            instValid_q <= instValid_d;
            fault_q     <= fault_d;
            kill_q      <= kill_d;
            killPc_q    <= killPc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        instPc_d    = instPc_q;
        instValid_d = instValid_q;
        fault_d     = fault_q;
        kill_d      = kill_q;
        killPc_d    = killPc_q;

        case (state_q)
            IDLE: begin
                if (redirect) pc_d = redirTarget;
                state_d = FETCH;
            end
            FETCH: begin
                // A redirect during an outstanding read is remembered in kill so the
                // wrong-path word is dropped when it finally arrives.
                if (mem_ack) begin
                    if (redirect) begin
                        pc_d   = redirTarget;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        pc_d   = killPc_q;
                        kill_d = 1'b0;
                    end else begin
                        inst_d      = mem_rdata;
                        instPc_d    = pc_q;
                        instValid_d = 1'b1;
                        pc_d        = pc_q + 32'd4;
                        state_d     = HOLD;
                    end
                end else if (redirect) begin
                    kill_d   = 1'b1;
                    killPc_d = redirTarget;
                end
            end
            HOLD: begin
                if (redirect) begin
                    instValid_d = 1'b0;
                    inst_d      = NOP_INST;
                    pc_d        = redirTarget;
                    state_d     = FETCH;
                end else if (dec_ready) begin
                    instValid_d = 1'b0;
                    inst_d      = NOP_INST;
                    state_d     = FETCH;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (misalign && (state_q != FAULT)) begin
            fault_d     = 1'b1;
            instValid_d = 1'b0;
            inst_d      = NOP_INST;
            kill_d      = 1'b0;
            state_d     = FAULT;
        end
    end

    assign mem_req    = (state_q == FETCH);
    assign mem_addr   = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = instPc_q;
    assign inst_valid = instValid_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; expected values are hand-computed.
// Build with FETCH_MISALIGN_TRAP_EN defined to exercise the fault path.
module tb_inst_fetch;

    logic        clk;
    logic        nreset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        dec_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    int checkCount = 0;
    int failCount  = 0;

    inst_fetch dut (
        .clk        (clk),
        .nreset     (nreset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic rdy,
                                 input logic redir, input logic [31:0] rpc);
        mem_ack     = ack;
        mem_rdata   = rdata;
        dec_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        nreset = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_req",   {31'b0, mem_req},    32'h0);
        checkOutput("rst_addr",  mem_addr,            32'h0);
        checkOutput("rst_inst",  inst,                32'h13);
        checkOutput("rst_ipc",   inst_pc,             32'h0);
        checkOutput("rst_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rst_fault", {31'b0, fault},      32'h0);

        $display("[TB] first fetch");
        nreset = 1'b1;
        checkOutput("idle_req", {31'b0, mem_req}, 32'h0);
        tick();
        checkOutput("f1_req",   {31'b0, mem_req}, 32'h1);
        checkOutput("f1_addr",  mem_addr,         32'h0);
        applyStimulus(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("f1_inst",  inst,                32'h0050_0093);
        checkOutput("f1_ipc",   inst_pc,             32'h0);
        checkOutput("f1_valid", {31'b0, inst_valid}, 32'h1);
        checkOutput("f1_hreq",  {31'b0, mem_req},    32'h0);

        $display("[TB] hold stall");
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_inst",  inst,                32'h0050_0093);
            checkOutput("hold_ipc",   inst_pc,             32'h0);
            checkOutput("hold_req",   {31'b0, mem_req},    32'h0);
            checkOutput("hold_valid", {31'b0, inst_valid}, 32'h1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("rel_inst",  inst,                32'h13);
        checkOutput("rel_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rel_req",   {31'b0, mem_req},    32'h1);
        checkOutput("rel_addr",  mem_addr,            32'h4);

        $display("[TB] redirect during outstanding fetch");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
        tick();
        idleInputs();
        for (int i = 0; i < 2; i++) begin
            checkOutput("kill_addr",  mem_addr,            32'h4);
            checkOutput("kill_valid", {31'b0, inst_valid}, 32'h0);
            tick();
        end
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("kill_drop",  {31'b0, inst_valid}, 32'h0);
        checkOutput("kill_dinst", inst,                32'h13);
        checkOutput("kill_req",   {31'b0, mem_req},    32'h1);
        checkOutput("kill_naddr", mem_addr,            32'h100);
        applyStimulus(1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("tgt_inst",  inst,                32'h00A0_0113);
        checkOutput("tgt_ipc",   inst_pc,             32'h100);
        checkOutput("tgt_valid", {31'b0, inst_valid}, 32'h1);

        $display("[TB] redirect and ready together, then PC wrap");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick();
        idleInputs();
        checkOutput("rr_valid", {31'b0, inst_valid}, 32'h0);
        checkOutput("rr_inst",  inst,                32'h13);
        checkOutput("rr_addr",  mem_addr,            32'hFFFF_FFFC);
        applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("wrap_inst", inst,    32'h1111_1111);
        checkOutput("wrap_ipc",  inst_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("wrap_addr", mem_addr,         32'h0);
        checkOutput("wrap_req",  {31'b0, mem_req}, 32'h1);

        $display("[TB] reset mid-fetch");
        applyStimulus(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("pre_addr", mem_addr, 32'h4);
        nreset = 1'b0;
        #1;
        checkOutput("ar_req",   {31'b0, mem_req},    32'h0);
        checkOutput("ar_addr",  mem_addr,            32'h0);
        checkOutput("ar_inst",  inst,                32'h13);
        checkOutput("ar_valid", {31'b0, inst_valid}, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h4444_4444, 1'b0, 1'b0, 32'h0);
        tick();
        nreset = 1'b1;
        tick();
        idleInputs();
        checkOutput("ar_ign",   {31'b0, inst_valid}, 32'h0);
        checkOutput("ar_req2",  {31'b0, mem_req},    32'h1);
        checkOutput("ar_raddr", mem_addr,            32'h0);
        applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("ar_inst2", inst,    32'h2222_2222);
        checkOutput("ar_ipc2",  inst_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        idleInputs();

        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0102);
        tick();
        idleInputs();
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            checkOutput("mis_fault", {31'b0, fault},      32'h1);
            checkOutput("mis_req",   {31'b0, mem_req},    32'h0);
            checkOutput("mis_valid", {31'b0, inst_valid}, 32'h0);
            applyStimulus(1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
            tick();
            idleInputs();
        end
        nreset = 1'b0;
        #1;
        checkOutput("mis_rst", {31'b0, fault}, 32'h0);
        @(negedge clk);
        nreset = 1'b1;
`else
        checkOutput("mis_fault0", {31'b0, fault}, 32'h0);
        checkOutput("mis_oaddr",  mem_addr,       32'h4);
        applyStimulus(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("mis_naddr", mem_addr,            32'h100);
        checkOutput("mis_drop",  {31'b0, inst_valid}, 32'h0);
        applyStimulus(1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h0);
        tick();
        idleInputs();
        checkOutput("mis_ipc",    inst_pc,        32'h100);
        checkOutput("mis_inst",   inst,           32'h0030_0193);
        checkOutput("mis_fault1", {31'b0, fault}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
